// File: rtl/fsk_ctrl_pkg.sv
// Shared state encoding and default symbol counts for the FSK burst controller.
// Pure declarations: no logic, no latency, no flow control.
package fsk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_GUARD    = 3'd4
  } state_t;

  localparam int DEF_PREAMBLE_LEN = 8;
  localparam int DEF_GUARD_LEN    = 4;

  // States whose duration is measured in symbols.
  function automatic logic counts_symbols(input state_t s);
    return (s == ST_PREAMBLE) || (s == ST_PAYLOAD) || (s == ST_GUARD);
  endfunction

endpackage

// File: rtl/sym_counter.sv
// Symbol counter with terminal compare; hit is combinational on the stepping cycle.
// Count updates one cycle after step/clear; clear wins over step; never stalls.
module sym_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       step,
  input  logic [7:0] terminal,
  output logic [7:0] count,
  output logic       hit
);

  assign hit = step && (count == terminal);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (step) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/fsk_burst_ctrl.sv
// FSK burst sequencer: IDLE -> SYNC -> PREAMBLE -> PAYLOAD -> GUARD, advancing on READY strobes.
// Outputs registered one cycle after the transition (LFSR_EN is combinational); no backpressure.
module fsk_burst_ctrl
  import fsk_ctrl_pkg::*;
#(
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter int GUARD_LEN    = DEF_GUARD_LEN
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       READY,
  input  logic       START,
  input  logic       STOP,
  input  logic [7:0] CFG_PAY_LEN,
  input  logic       CFG_REPEAT,
  output logic       LFSR_EN,
  output logic       PRE_SEL,
  output logic       PRE_BIT,
  output logic       TX_EN,
  output logic       BUSY,
  output logic       DONE,
  output logic [2:0] STATE,
  output logic [7:0] SYM_CNT
);

  localparam logic [7:0] PRE_TERM = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GRD_TERM = 8'(GUARD_LEN - 1);

  state_t     state;
  state_t     nxt;
  logic [7:0] pay_len;
  logic       rep;
  logic       stop_pend;
  logic       step;
  logic       clear;
  logic       hit;
  logic [7:0] terminal;
  logic [7:0] count;

  assign step    = READY && counts_symbols(state);
  assign clear   = (nxt != state);
  assign STATE   = state;
  assign SYM_CNT = count;
  assign LFSR_EN = RESET_N && READY && (state == ST_PAYLOAD);

  always_comb begin
    terminal = '0;
    case (state)
      ST_PREAMBLE: terminal = PRE_TERM;
      ST_PAYLOAD:  terminal = pay_len - 8'd1;
      ST_GUARD:    terminal = GRD_TERM;
      default:     terminal = '0;
    endcase
  end

  sym_counter u_sym_counter (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .clear    (clear),
    .step     (step),
    .terminal (terminal),
    .count    (count),
    .hit      (hit)
  );

  // A pending stop cuts the current state short at the next symbol boundary.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (START) nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (READY) nxt = stop_pend ? ST_GUARD : ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (READY && (stop_pend || hit))
          nxt = (stop_pend || (pay_len == 8'd0)) ? ST_GUARD : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (READY && (stop_pend || hit)) nxt = ST_GUARD;
      end
      ST_GUARD: begin
        if (hit) nxt = (rep && !stop_pend && !STOP) ? ST_PREAMBLE : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      pay_len   <= '0;
      rep       <= 1'b0;
      stop_pend <= 1'b0;
      TX_EN     <= 1'b0;
      PRE_SEL   <= 1'b0;
      PRE_BIT   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state   <= nxt;
      TX_EN   <= (nxt == ST_PREAMBLE) || (nxt == ST_PAYLOAD);
      PRE_SEL <= (nxt == ST_PREAMBLE);
      BUSY    <= (nxt != ST_IDLE);
      DONE    <= (state == ST_GUARD) && (nxt == ST_IDLE);

      if ((state == ST_IDLE) && START) begin
        pay_len <= CFG_PAY_LEN;
        rep     <= CFG_REPEAT;
      end

      if (nxt == ST_IDLE) begin
        stop_pend <= 1'b0;
      end else if (STOP && (state != ST_IDLE)) begin
        stop_pend <= 1'b1;
      end

      // Alternating preamble starts at 1 on every entry, including repeats.
      if (nxt != ST_PREAMBLE) begin
        PRE_BIT <= 1'b0;
      end else if (state != ST_PREAMBLE) begin
        PRE_BIT <= 1'b1;
      end else if (READY) begin
        PRE_BIT <= ~PRE_BIT;
      end
    end
  end

endmodule

// File: tb/tb_fsk_burst_ctrl.sv
// Self-checking bench for fsk_burst_ctrl: vector table of single bursts plus hand-written
// sequences for coincident START/READY, repeat looping and mid-burst reset.
module tb_fsk_burst_ctrl;
  import fsk_ctrl_pkg::*;

  localparam int PL = 4;
  localparam int GL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cfg_pay_len = 8'd0;
  logic       cfg_repeat = 1'b0;
  logic       lfsr_en, pre_sel, pre_bit, tx_en, busy, done;
  logic [2:0] state;
  logic [7:0] sym_cnt;

  fsk_burst_ctrl #(.PREAMBLE_LEN(PL), .GUARD_LEN(GL)) dut (
    .CLOCK       (clk),
    .RESET_N     (rst_n),
    .READY       (ready),
    .START       (start),
    .STOP        (stop),
    .CFG_PAY_LEN (cfg_pay_len),
    .CFG_REPEAT  (cfg_repeat),
    .LFSR_EN     (lfsr_en),
    .PRE_SEL     (pre_sel),
    .PRE_BIT     (pre_bit),
    .TX_EN       (tx_en),
    .BUSY        (busy),
    .DONE        (done),
    .STATE       (state),
    .SYM_CNT     (sym_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gap;
    int pay;
    int rep;
    int stop_at;
    int exp_lfsr;
    int exp_pre;
    int exp_grd;
    int exp_tx;
  } vec_t;

  vec_t vecs[6];

  int errors = 0;
  int checks = 0;
  int gap = 8;
  int rcnt = 0;
  bit mon_en = 1'b0;
  int lfsr_cnt, pre_rdy, grd_rdy, sync_rdy, sync_cyc, done_cnt, tx_sym, busy_low, idx;
  logic [2:0] prev_state = 3'd0;
  logic [2:0] exp_q[$];
  logic       pre_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    if (!mon_en) return;
    if (state != prev_state) begin
      check("state_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("state_seq", int'(state), int'(exp_q.pop_front()));
      prev_state = state;
      idx = 0;
    end
    if (state == ST_SYNC) begin
      sync_cyc++;
      if (ready) sync_rdy++;
    end
    if (lfsr_en) lfsr_cnt++;
    if (!busy) busy_low++;
    if (done) begin
      done_cnt++;
      check("done_in_idle", int'(state), int'(ST_IDLE));
    end
    if (ready && (state == ST_PREAMBLE || state == ST_PAYLOAD || state == ST_GUARD)) begin
      check("sym_cnt", int'(sym_cnt), idx);
      idx++;
      check("tx_presel_busy", int'({tx_en, pre_sel, busy}),
            int'({state != ST_GUARD, state == ST_PREAMBLE, 1'b1}));
      if (tx_en) tx_sym++;
      if (state == ST_GUARD) grd_rdy++;
      if (state == ST_PREAMBLE) begin
        pre_rdy++;
        check("pre_bit_expected", int'(pre_q.size() > 0), 1);
        if (pre_q.size() > 0) check("pre_bit", int'(pre_bit), int'(pre_q.pop_front()));
      end
    end
  endtask

  // One clock: READY strobes every gap cycles, outputs sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    rcnt  = (rcnt >= gap - 1) ? 0 : rcnt + 1;
    ready = (rcnt == gap - 1);
    #1;
    monitor();
  endtask

  task automatic clear_counts();
    lfsr_cnt = 0; pre_rdy = 0; grd_rdy = 0; sync_rdy = 0; sync_cyc = 0;
    done_cnt = 0; tx_sym = 0; busy_low = 0;
  endtask

  task automatic expect_bursts(input int nb, input bit has_pay);
    exp_q.push_back(ST_SYNC);
    for (int b = 0; b < nb; b++) begin
      exp_q.push_back(ST_PREAMBLE);
      for (int i = 0; i < PL; i++) pre_q.push_back((i % 2) == 0);
      if (has_pay) exp_q.push_back(ST_PAYLOAD);
      exp_q.push_back(ST_GUARD);
    end
    exp_q.push_back(ST_IDLE);
  endtask

  // Start a burst, then scramble config and re-pulse START while busy.
  task automatic start_burst(input logic [7:0] pay, input logic rep);
    clear_counts();
    cfg_pay_len = pay;
    cfg_repeat  = rep;
    start       = 1'b1;
    tick();
    cfg_pay_len = ~pay;
    cfg_repeat  = ~rep;
    tick();
    start = 1'b0;
  endtask

  task automatic run_burst(input int limit, input int stop_pay, input int stop_grd);
    int n = 0;
    bit stopped = 1'b0;
    while (!(done_cnt > 0 && state == ST_IDLE) && n < limit) begin
      tick();
      n++;
      stop = 1'b0;
      if (!stopped && !ready && stop_pay > 0 && state == ST_PAYLOAD && lfsr_cnt == stop_pay - 1) begin
        stop = 1'b1;
        stopped = 1'b1;
      end
      if (!stopped && !ready && stop_grd > 0 && state == ST_GUARD && grd_rdy == stop_grd) begin
        stop = 1'b1;
        stopped = 1'b1;
      end
    end
    stop = 1'b0;
    check("burst_timeout", int'(n >= limit), 0);
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{128,   6, 0, 0,   6, PL, GL,  10};
    vecs[1] = '{  8,   0, 0, 0,   0, PL, GL,   4};
    vecs[2] = '{  8,   6, 1, 3,   3, PL, GL,   7};
    vecs[3] = '{  5,   1, 0, 0,   1, PL, GL,   5};
    vecs[4] = '{  8, 255, 0, 0, 255, PL, GL, 259};
    vecs[5] = '{  8,   6, 0, 1,   1, PL, GL,   5};

    // Reset state
    repeat (3) tick();
    check("reset_outputs",
          int'({state, sym_cnt, tx_en, pre_sel, pre_bit, busy, done, lfsr_en}), 0);
    rst_n = 1'b1;
    prev_state = ST_IDLE;
    mon_en = 1'b1;
    repeat (3) tick();

    for (int k = 0; k < 6; k++) begin
      gap  = vecs[k].gap;
      rcnt = 0;
      expect_bursts(1, vecs[k].pay != 0);
      start_burst(8'(vecs[k].pay), 1'(vecs[k].rep));
      run_burst(vecs[k].gap * (PL + GL + vecs[k].pay + 4) + 50, vecs[k].stop_at, 0);
      check("lfsr_pulses", lfsr_cnt, vecs[k].exp_lfsr);
      check("pre_readys", pre_rdy, vecs[k].exp_pre);
      check("guard_readys", grd_rdy, vecs[k].exp_grd);
      check("tx_symbols", tx_sym, vecs[k].exp_tx);
      check("sync_readys", sync_rdy, 1);
      check("done_pulses", done_cnt, 1);
      check("busy_low_cycles", busy_low, 5);
      check("state_q_left", exp_q.size(), 0);
      check("pre_q_left", pre_q.size(), 0);
    end

    // START coincident with READY in IDLE: SYNC lasts a full symbol period.
    begin
      int n = 0;
      gap = 8;
      rcnt = 0;
      while (!ready && n < 20) begin
        tick();
        n++;
      end
      check("align_ready", int'(ready), 1);
      clear_counts();
      expect_bursts(1, 1'b1);
      cfg_pay_len = 8'd2;
      cfg_repeat  = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("coincident_sync", int'(state), int'(ST_SYNC));
      run_burst(400, 0, 0);
      check("coincident_sync_cycles", sync_cyc, 8);
      check("coincident_sync_readys", sync_rdy, 1);
      check("coincident_lfsr", lfsr_cnt, 2);
      check("coincident_done", done_cnt, 1);
    end

    // Repeat for three bursts; STOP during the third guard ends the loop.
    gap  = 6;
    rcnt = 0;
    expect_bursts(3, 1'b1);
    start_burst(8'd3, 1'b1);
    run_burst(3 * 6 * (PL + 3 + GL) + 200, 0, 2 * GL);
    check("repeat_busy_low", busy_low, 5);
    check("repeat_lfsr", lfsr_cnt, 9);
    check("repeat_pre_readys", pre_rdy, 3 * PL);
    check("repeat_guard_readys", grd_rdy, 3 * GL);
    check("repeat_done", done_cnt, 1);
    check("repeat_state_q_left", exp_q.size(), 0);

    // One-cycle reset mid-PAYLOAD on a READY cycle.
    begin
      int n = 0;
      gap  = 8;
      rcnt = 0;
      exp_q.push_back(ST_SYNC);
      exp_q.push_back(ST_PREAMBLE);
      exp_q.push_back(ST_PAYLOAD);
      exp_q.push_back(ST_IDLE);
      for (int i = 0; i < PL; i++) pre_q.push_back((i % 2) == 0);
      start_burst(8'd6, 1'b0);
      while (!(state == ST_PAYLOAD && ready) && n < 400) begin
        tick();
        n++;
      end
      check("reach_payload", int'(state == ST_PAYLOAD && ready), 1);
      rst_n = 1'b0;
      #1;
      check("lfsr_en_in_reset", int'(lfsr_en), 0);
      tick();
      check("midreset_outputs",
            int'({state, sym_cnt, tx_en, pre_sel, pre_bit, busy, done, lfsr_en}), 0);
      rst_n = 1'b1;
      repeat (20) tick();
      check("midreset_no_done", done_cnt, 0);
      check("midreset_idle", int'(state), int'(ST_IDLE));
      check("midreset_state_q_left", exp_q.size(), 0);
      check("midreset_pre_q_left", pre_q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
